// File: rtl/reg_if_id.sv
// -----------------------------------------------------------------------------
// reg_if_id
//   IF/ID pipeline register between fetch and decode. Captures the fetched
//   instruction and PC+4 on each rising edge, and hands them to decode one
//   cycle later. It supports:
//     - stall  : hold the current contents (hazard unit request)
//     - flush  : insert a bubble (taken branch/jump resolved in ID)
//     - a valid bit and a 2-bit occupancy state
//   It also keeps three saturating performance counters.
//
//   Per-edge priority is flush > stall > load.
//
// Parameters
//   NOP_INSTR : instruction word injected on reset/flush (sll $0,$0,0)
//   CNT_W     : performance counter width, legal range 8..32
//
// Ports
//   clk       in   system clock, rising-edge active
//   rst       in   asynchronous, active-high reset
//   stall     in   hold request from the hazard unit
//   flush     in   kill the instruction being fetched
//   Instr_IF  in   [31:0] instruction from fetch
//   pc4_IF    in   [31:0] PC+4 from fetch
//   Instr_ID  out  [31:0] registered instruction to decode
//   pc4_ID    out  [31:0] registered PC+4 to decode
//   valid_ID  out  Instr_ID holds a real instruction, not a bubble
//   state_ID  out  [1:0] 0 EMPTY, 1 VALID, 2 HELD
//   cnt_fetch out  [CNT_W-1:0] instructions accepted into ID
//   cnt_stall out  [CNT_W-1:0] cycles with stall=1 and flush=0
//   cnt_flush out  [CNT_W-1:0] cycles with flush=1
//
// Optional build macro
//   IF_ID_TRACE_EN : when defined, every rising edge with rst=0 prints one
//                    simulation line (action, pc4_ID-4, Instr_ID after the
//                    update). This is simulation-only code, and it does not
//                    change pipeline or counter behaviour.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module reg_if_id #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      Instr_IF,
  input  logic [31:0]      pc4_IF,
  output logic [31:0]      Instr_ID,
  output logic [31:0]      pc4_ID,
  output logic             valid_ID,
  output logic [1:0]       state_ID,
  output logic [CNT_W-1:0] cnt_fetch,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_VALID = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  state_t state;

  assign state_ID = state;

  // Saturating increment: once the counter reaches all-ones it sticks there
  // instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments only. Every
  // register in this block, including the counters, is cleared on the
  // asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Instr_ID  <= NOP_INSTR;
      pc4_ID    <= '0;
      valid_ID  <= 1'b0;
      state     <= ST_EMPTY;
      cnt_fetch <= '0;
      cnt_stall <= '0;
      cnt_flush <= '0;
    end else if (flush) begin
      // Flush beats stall, so a killed slot can never be preserved by a hold.
      Instr_ID  <= NOP_INSTR;
      pc4_ID    <= '0;
      valid_ID  <= 1'b0;
      state     <= ST_EMPTY;
      cnt_flush <= sat_inc(cnt_flush);
    end else if (stall) begin
      // Data and valid hold. A bubble being held stays EMPTY; it is not HELD.
      state     <= valid_ID ? ST_HELD : ST_EMPTY;
      cnt_stall <= sat_inc(cnt_stall);
    end else begin
      Instr_ID  <= Instr_IF;
      pc4_ID    <= pc4_IF;
      valid_ID  <= 1'b1;
      state     <= ST_VALID;
      cnt_fetch <= sat_inc(cnt_fetch);
    end
  end

`ifdef IF_ID_TRACE_EN
  // The post-edge values are rebuilt from the pre-edge values, so the line
  // printed matches what the register holds after this edge.
  always @(posedge clk) begin
    if (!rst) begin
      if (flush)
        $display("[%0t] IF/ID FLUSH pc=%08h instr=%08h", $time,
                 32'h0 - 32'd4, NOP_INSTR);
      else if (stall)
        $display("[%0t] IF/ID HOLD  pc=%08h instr=%08h", $time,
                 pc4_ID - 32'd4, Instr_ID);
      else
        $display("[%0t] IF/ID LOAD  pc=%08h instr=%08h", $time,
                 pc4_IF - 32'd4, Instr_IF);
    end
  end
`endif

endmodule

// File: tb/tb_reg_if_id.sv
`timescale 1ns/1ps

module tb_reg_if_id;

  localparam int unsigned CNT_W = 8;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall;
  logic             flush;
  logic [31:0]      instr_if;
  logic [31:0]      pc4_if;
  logic [31:0]      instr_id;
  logic [31:0]      pc4_id;
  logic             valid_id;
  logic [1:0]       state_id;
  logic [CNT_W-1:0] cnt_fetch;
  logic [CNT_W-1:0] cnt_stall;
  logic [CNT_W-1:0] cnt_flush;

  reg_if_id #(.NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .flush    (flush),
    .Instr_IF (instr_if),
    .pc4_IF   (pc4_if),
    .Instr_ID (instr_id),
    .pc4_ID   (pc4_id),
    .valid_ID (valid_id),
    .state_ID (state_id),
    .cnt_fetch(cnt_fetch),
    .cnt_stall(cnt_stall),
    .cnt_flush(cnt_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      instr;
    logic [31:0]      pc4;
    logic             valid;
    logic [1:0]       state;
    logic [CNT_W-1:0] fetch;
    logic [CNT_W-1:0] stl;
    logic [CNT_W-1:0] fl;
  } exp_t;

  exp_t sb_q[$];
  exp_t m;            // reference model of the register contents
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  function automatic exp_t reset_model();
    exp_t r;
    r.instr = NOP; r.pc4 = '0; r.valid = 1'b0; r.state = 2'd0;
    r.fetch = '0;  r.stl = '0; r.fl = '0;
    return r;
  endfunction

  // Pop the oldest expectation and compare it with every DUT output.
  task automatic compare_head(input string tag);
    exp_t e;
    check({tag, ".sb_depth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, ".instr"}, instr_id,          e.instr);
      check({tag, ".pc4"},   pc4_id,            e.pc4);
      check({tag, ".valid"}, 32'(valid_id),     32'(e.valid));
      check({tag, ".state"}, 32'(state_id),     32'(e.state));
      check({tag, ".fetch"}, 32'(cnt_fetch),    32'(e.fetch));
      check({tag, ".stall"}, 32'(cnt_stall),    32'(e.stl));
      check({tag, ".flush"}, 32'(cnt_flush),    32'(e.fl));
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge state, and check it
  // 1 ns after the rising edge.
  task automatic cycle(input string tag, input logic s, input logic f,
                       input logic [31:0] i, input logic [31:0] p);
    @(negedge clk);
    rst = 1'b0; stall = s; flush = f; instr_if = i; pc4_if = p;
    if (f) begin
      m.instr = NOP; m.pc4 = '0; m.valid = 1'b0; m.state = 2'd0;
      m.fl = sat(m.fl);
    end else if (s) begin
      m.state = m.valid ? 2'd2 : 2'd0;
      m.stl   = sat(m.stl);
    end else begin
      m.instr = i; m.pc4 = p; m.valid = 1'b1; m.state = 2'd1;
      m.fetch = sat(m.fetch);
    end
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    compare_head(tag);
  endtask

  // Assert reset between edges; the outputs must clear without waiting for a clock edge.
  task automatic reset_between_edges(input string tag);
    #2;
    rst = 1'b1;
    m = reset_model();
    sb_q.push_back(m);
    #1;
    compare_head(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; instr_if = '0; pc4_if = '0;
    m = reset_model();
    #12;
    sb_q.push_back(m);
    compare_head("por");

    // 1. reset in the middle of operation
    cycle("t1.load", 1'b0, 1'b0, 32'h2008_0005, 32'h0000_3004);
    reset_between_edges("t1.rst");

    // 2. three back-to-back loads
    cycle("t2.a", 1'b0, 1'b0, 32'hAAAA_0001, 32'h0000_0004);
    cycle("t2.b", 1'b0, 1'b0, 32'hBBBB_0002, 32'h0000_0008);
    cycle("t2.c", 1'b0, 1'b0, 32'hCCCC_0003, 32'h0000_000C);

    // 3. stall holds the instruction while the fetch input keeps changing
    cycle("t3.load",  1'b0, 1'b0, 32'h8C08_0000, 32'h0000_0010);
    cycle("t3.stl1",  1'b1, 1'b0, 32'h1111_1111, 32'h0000_0014);
    cycle("t3.stl2",  1'b1, 1'b0, 32'h2222_2222, 32'h0000_0018);
    cycle("t3.rel",   1'b0, 1'b0, 32'h3333_3333, 32'h0000_0014);

    // 4. flush and stall on the same edge, with a valid instruction held
    cycle("t4.hold",  1'b1, 1'b0, 32'h4444_4444, 32'h0000_0020);
    cycle("t4.both",  1'b1, 1'b1, 32'h5555_5555, 32'h0000_0024);

    // 5. stall while EMPTY stays EMPTY; then a plain flush after a load
    cycle("t5.stl",   1'b1, 1'b0, 32'h6666_6666, 32'h0000_0028);
    cycle("t5.load",  1'b0, 1'b0, 32'h7777_7777, 32'h0000_002C);
    cycle("t5.flush", 1'b0, 1'b1, 32'h8888_8888, 32'h0000_0030);

    // reset asserted while the register is held by a stall
    cycle("t5b.load", 1'b0, 1'b0, 32'h9999_9999, 32'h0000_0034);
    cycle("t5b.stl",  1'b1, 1'b0, 32'hABCD_0000, 32'h0000_0038);
    reset_between_edges("t5b.rst");

    // 6. saturation of the 8-bit fetch counter; data must keep flowing
    for (int k = 0; k < 260; k++) begin
      cycle("t6.load", 1'b0, 1'b0, $urandom(), 32'(4 * (k + 1)));
    end
    check("t6.sat", 32'(cnt_fetch), 32'h0000_00FF);
    cycle("t6.stl",   1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_1000);
    cycle("t6.rel",   1'b0, 1'b0, 32'hFEED_F00D, 32'h0000_1004);
    cycle("t6.flush", 1'b1, 1'b1, 32'h0BAD_0BAD, 32'h0000_1008);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_if_id.md
Name: reg_if_id

Overview:
IF/ID pipeline register directly downstream of the fetch stage. Captures the fetched instruction and PC+4 each cycle, then presents them to decode. Supports stall (hold), flush (bubble on taken branch/jump) and a valid bit. Also carries three saturating performance counters (fetched, stalled, flushed) for the CPU status block.

Parameters:
NOP_INSTR, 32'h0000_0000, instruction word injected on reset/flush (sll $0,$0,0)
CNT_W, 32, width of each performance counter (legal 8..32)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  hazard unit hold request; same signal that freezes the PC
flush  in  1  taken branch/jump resolved in ID (PcSrc != 0); kill the instruction being fetched
Instr_IF  in  32  instruction from fetch stage
pc4_IF  in  32  PC+4 from fetch stage
Instr_ID  out  32  registered instruction to decode
pc4_ID  out  32  registered PC+4 to decode
valid_ID  out  1  Instr_ID is a real instruction, not a bubble
state_ID  out  2  register state: 0 EMPTY, 1 VALID, 2 HELD
cnt_fetch  out  CNT_W  instructions accepted into ID
cnt_stall  out  CNT_W  cycles with stall asserted and flush not asserted
cnt_flush  out  CNT_W  cycles with flush asserted

Behaviour:
- Reset (async, any time, including mid-stall): Instr_ID=NOP_INSTR, pc4_ID=0, valid_ID=0, state=EMPTY, all counters 0. First capture happens on the first rising edge after rst falls.
- Per-edge priority: flush > stall > load.
- flush=1: Instr_ID<=NOP_INSTR, pc4_ID<=0, valid_ID<=0, state<=EMPTY. Flush wins even when stall=1 on the same edge; the flushed slot must not survive a stall.
- flush=0, stall=1: Instr_ID, pc4_ID and valid_ID are held. State becomes HELD if valid_ID=1, otherwise it stays EMPTY.
- flush=0, stall=0: Instr_ID<=Instr_IF, pc4_ID<=pc4_IF, valid_ID<=1, state<=VALID.
- Latency: 1 cycle from IF inputs to ID outputs. No combinational path from inputs to outputs.
- State transitions:
  - EMPTY -> VALID on load.
  - VALID -> HELD on stall.
  - HELD -> VALID on load.
  - Any state -> EMPTY on flush or reset.
  - HELD with a continued stall stays HELD.
- Counters:
  - cnt_fetch increments on each load edge.
  - cnt_stall increments when stall=1 and flush=0.
  - cnt_flush increments when flush=1.
  - All counters saturate at all-ones and never wrap.
- Counters are CNT_W wide, unsigned, updated on the same edge as the pipeline register. Reading a counter returns its value after that edge.
- X on the stall or flush inputs is illegal; the hazard unit guarantees 0/1 after reset.

Optional Feature:
IF_ID_TRACE_EN
- Defined: every rising edge with rst=0 prints one simulation line via $display showing cycle action (LOAD/HOLD/FLUSH), pc4_ID-4 and Instr_ID after update. The print is non-synthesisable and wrapped in the macro.
- Undefined: no display code and no counters are affected. Pipeline and counter behaviour are identical in both builds.

Test Plan:
1. Reset mid-operation: load Instr_IF=32'h2008_0005, pc4_IF=32'h0000_3004, then assert rst between edges -> outputs immediately NOP_INSTR/0, valid_ID=0, state=0, counters 0.
2. Stream: three edges with stall=flush=0, Instr_IF=A,B,C (pc4 4,8,C) -> Instr_ID follows one cycle later (A,B,C), valid_ID=1, state=1, cnt_fetch=3.
3. Stall hold: load 32'h8C08_0000, then stall=1 for 2 edges while Instr_IF changes -> Instr_ID stays 32'h8C08_0000, state=2, cnt_stall=2, cnt_fetch unchanged; release -> next instruction loads, state=1.
4. Flush vs stall: stall=1 and flush=1 on the same edge with a valid instruction held -> Instr_ID=NOP_INSTR, valid_ID=0, state=0, cnt_flush+1, cnt_stall unchanged.
5. Stall while EMPTY: after a flush, stall=1 for one edge -> state stays 0, valid_ID=0, cnt_stall+1.
6. Saturation: CNT_W=8, 260 load edges -> cnt_fetch=8'hFF and holds; pipeline data still correct.
